// File: rtl/alu_mdu.sv
// ALU with an iterative multiply/divide unit.
//
// Single-cycle ops (logic, add/sub, compares, shifts) produce r/intov in
// the cycle after acceptance. MULT/MULTU/DIV/DIVU run one bit per cycle
// for WIDTH cycles on operand magnitudes, with the sign fixed on the last
// step. The result pulses out_valid WIDTH+1 cycles after acceptance.
//
// Ports
//   clk       rising-edge clock
//   reset     asynchronous, active-low reset
//   in_valid  operation presented this cycle
//   in_ready  block can accept an operation (IDLE only)
//   a, b      operands; for shifts a = amount, b = value shifted
//   control   5-bit opcode
//   cancel    abort an operation in progress (honoured only while iterating)
//   out_valid one-cycle result pulse
//   r         single-cycle result
//   hi, lo    product {hi,lo}, or remainder (hi) and quotient (lo)
//   intov     signed overflow of ADD/SUB, 0 for every other op
module alu_mdu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [4:0]       control,
    input  logic             cancel,
    output logic             out_valid,
    output logic [WIDTH-1:0] r,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             intov
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST    = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    localparam logic [4:0] OP_AND   = 5'b00000;
    localparam logic [4:0] OP_OR    = 5'b01000;
    localparam logic [4:0] OP_NOR   = 5'b10000;
    localparam logic [4:0] OP_XOR   = 5'b11000;
    localparam logic [4:0] OP_ADD   = 5'b00001;
    localparam logic [4:0] OP_SUB   = 5'b01001;
    localparam logic [4:0] OP_SLT   = 5'b01010;
    localparam logic [4:0] OP_SLTU  = 5'b01011;
    localparam logic [4:0] OP_SRL   = 5'b00100;
    localparam logic [4:0] OP_SRA   = 5'b01100;
    localparam logic [4:0] OP_SLL   = 5'b10100;
    localparam logic [4:0] OP_MULT  = 5'b00010;
    localparam logic [4:0] OP_MULTU = 5'b00011;
    localparam logic [4:0] OP_DIV   = 5'b00110;
    localparam logic [4:0] OP_DIVU  = 5'b00111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Magnitude of v when interpreted as signed; the most negative value maps
    // to 2^(WIDTH-1), which is still exact as an unsigned number.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
        if (sgn && v[WIDTH-1]) begin
            return -v;
        end else begin
            return v;
        end
    endfunction

    state_t            state_r;
    state_t            state_nxt_s;
    logic [CW-1:0]     cnt_r;
    logic              accept_s;
    logic              is_multi_s;
    logic              signed_op_s;
    logic              last_s;

    logic [WIDTH-1:0]  sum_s;
    logic [WIDTH-1:0]  diff_s;
    logic [SHW-1:0]    amt_s;
    logic [WIDTH-1:0]  alu_res_s;
    logic              alu_ov_s;

    // Iteration registers: acc_r is the partial product high half or the
    // partial remainder; sh_r is the multiplier or the dividend/quotient.
    logic [WIDTH-1:0]  a_r;
    logic [WIDTH-1:0]  acc_r;
    logic [WIDTH-1:0]  sh_r;
    logic [WIDTH-1:0]  opd_r;
    logic              is_div_r;
    logic              neg_q_r;
    logic              neg_rem_r;
    logic              dz_r;

    logic [WIDTH:0]    mul_sum_s;
    logic [WIDTH:0]    div_shift_s;
    logic [WIDTH:0]    div_diff_s;
    logic [WIDTH-1:0]  step_acc_s;
    logic [WIDTH-1:0]  step_sh_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] prod_fin_s;
    logic [WIDTH-1:0]  fin_hi_s;
    logic [WIDTH-1:0]  fin_lo_s;

    assign accept_s    = in_valid && (state_r == IDLE);
    assign signed_op_s = ~control[0];
    assign last_s      = (state_r == CALC) && !cancel && (cnt_r == LAST);
    assign sum_s       = a + b;
    assign diff_s      = a - b;
    assign amt_s       = a[SHW-1:0];

    // Classify the presented opcode as multi-cycle or not.
    always_comb begin
        is_multi_s = 1'b0;
        case (control)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: is_multi_s = 1'b1;
            default:                            is_multi_s = 1'b0;
        endcase
    end

    // Single-cycle result and ADD/SUB overflow, computed from the live inputs
    // and captured on the accepting edge.
    always_comb begin
        alu_res_s = '0;
        alu_ov_s  = 1'b0;
        case (control)
            OP_AND:  alu_res_s = a & b;
            OP_OR:   alu_res_s = a | b;
            OP_NOR:  alu_res_s = ~(a | b);
            OP_XOR:  alu_res_s = a ^ b;
            OP_ADD: begin
                alu_res_s = sum_s;
                alu_ov_s  = (a[WIDTH-1] == b[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res_s = diff_s;
                alu_ov_s  = (a[WIDTH-1] != b[WIDTH-1]) && (diff_s[WIDTH-1] != a[WIDTH-1]);
            end
            // Direct comparators, so no subtraction overflow can corrupt them.
            OP_SLT:  alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: alu_res_s = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SRL:  alu_res_s = b >> amt_s;
            OP_SRA:  alu_res_s = $signed(b) >>> amt_s;
            OP_SLL:  alu_res_s = b << amt_s;
            default: alu_res_s = '0;
        endcase
    end

    // One shift-add or one restoring-division step on the iteration registers.
    always_comb begin
        mul_sum_s   = {1'b0, acc_r} + ({1'b0, opd_r} & {(WIDTH+1){sh_r[0]}});
        div_shift_s = {acc_r, sh_r[WIDTH-1]};
        div_diff_s  = div_shift_s - {1'b0, opd_r};
        step_acc_s  = acc_r;
        step_sh_s   = sh_r;
        if (!is_div_r) begin
            step_acc_s = mul_sum_s[WIDTH:1];
            step_sh_s  = {mul_sum_s[0], sh_r[WIDTH-1:1]};
        end else if (!div_diff_s[WIDTH]) begin
            step_acc_s = div_diff_s[WIDTH-1:0];
            step_sh_s  = {sh_r[WIDTH-2:0], 1'b1};
        end else begin
            step_acc_s = div_shift_s[WIDTH-1:0];
            step_sh_s  = {sh_r[WIDTH-2:0], 1'b0};
        end
    end

    // Sign correction applied to the final step. Divide by zero bypasses the
    // datapath; most-negative / -1 falls out naturally as 2^(WIDTH-1).
    always_comb begin
        prod_s     = {step_acc_s, step_sh_s};
        prod_fin_s = prod_s;
        fin_hi_s   = '0;
        fin_lo_s   = '0;
        if (neg_q_r) begin
            prod_fin_s = -prod_s;
        end else begin
            prod_fin_s = prod_s;
        end
        if (!is_div_r) begin
            fin_hi_s = prod_fin_s[2*WIDTH-1:WIDTH];
            fin_lo_s = prod_fin_s[WIDTH-1:0];
        end else if (dz_r) begin
            fin_hi_s = a_r;
            fin_lo_s = '1;
        end else begin
            fin_hi_s = neg_rem_r ? -step_acc_s : step_acc_s;
            fin_lo_s = neg_q_r   ? -step_sh_s  : step_sh_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = is_multi_s ? CALC : DONE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CALC: begin
                if (cancel) begin
                    state_nxt_s = IDLE;
                end else if (cnt_r == LAST) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = CALC;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Operand capture, iteration registers and iteration counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_r       <= '0;
            acc_r     <= '0;
            sh_r      <= '0;
            opd_r     <= '0;
            is_div_r  <= 1'b0;
            neg_q_r   <= 1'b0;
            neg_rem_r <= 1'b0;
            dz_r      <= 1'b0;
            cnt_r     <= '0;
        end else begin
            if (accept_s) begin
                a_r       <= a;
                acc_r     <= '0;
                sh_r      <= mag(a, signed_op_s);
                opd_r     <= mag(b, signed_op_s);
                is_div_r  <= control[2];
                neg_q_r   <= signed_op_s & (a[WIDTH-1] ^ b[WIDTH-1]);
                neg_rem_r <= signed_op_s & a[WIDTH-1];
                dz_r      <= (b == '0);
            end else if (state_r == CALC) begin
                acc_r <= step_acc_s;
                sh_r  <= step_sh_s;
            end
            // Counts 0..WIDTH at most, which fits CW bits, so it never wraps.
            if ((state_r == CALC) && !cancel) begin
                cnt_r <= cnt_r + CNT_ONE;
            end else begin
                cnt_r <= '0;
            end
        end
    end

    // Registered outputs and handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            r         <= '0;
            hi        <= '0;
            lo        <= '0;
            intov     <= 1'b0;
        end else begin
            out_valid <= (state_nxt_s == DONE);
            in_ready  <= (state_nxt_s == IDLE);
            if (accept_s && !is_multi_s) begin
                r     <= alu_res_s;
                intov <= alu_ov_s;
            end else if (last_s) begin
                hi    <= fin_hi_s;
                lo    <= fin_lo_s;
                intov <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu: directed vectors, randomized ops against
// a plain-arithmetic reference model, cancel, reset abort, issue interval,
// and an 8-bit instance for the narrow-width multiply/divide path.
module tb_alu_mdu;

    localparam logic [4:0] OP_AND   = 5'b00000;
    localparam logic [4:0] OP_OR    = 5'b01000;
    localparam logic [4:0] OP_NOR   = 5'b10000;
    localparam logic [4:0] OP_XOR   = 5'b11000;
    localparam logic [4:0] OP_ADD   = 5'b00001;
    localparam logic [4:0] OP_SUB   = 5'b01001;
    localparam logic [4:0] OP_SLT   = 5'b01010;
    localparam logic [4:0] OP_SLTU  = 5'b01011;
    localparam logic [4:0] OP_SRL   = 5'b00100;
    localparam logic [4:0] OP_SRA   = 5'b01100;
    localparam logic [4:0] OP_SLL   = 5'b10100;
    localparam logic [4:0] OP_MULT  = 5'b00010;
    localparam logic [4:0] OP_MULTU = 5'b00011;
    localparam logic [4:0] OP_DIV   = 5'b00110;
    localparam logic [4:0] OP_DIVU  = 5'b00111;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, cancel, out_valid, intov;
    logic [31:0] a, b, r, hi, lo;
    logic [4:0]  control;

    logic        in_valid8, in_ready8, cancel8, out_valid8, intov8;
    logic [7:0]  a8, b8, r8, hi8, lo8;
    logic [4:0]  control8;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;

    logic [31:0] exp_r, exp_hi, exp_lo;
    logic        exp_ov;
    int          exp_lat;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    alu_mdu #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .control(control), .cancel(cancel), .out_valid(out_valid),
        .r(r), .hi(hi), .lo(lo), .intov(intov)
    );

    alu_mdu #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .control(control8), .cancel(cancel8), .out_valid(out_valid8),
        .r(r8), .hi(hi8), .lo(lo8), .intov(intov8)
    );

    // Reference model: updates the expected architectural outputs from the
    // operation's arithmetic meaning, using 64-bit integers.
    task automatic model(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y);
        longint      sx, sy, p;
        logic [63:0] up;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        exp_lat = 1;
        case (op)
            OP_AND:  begin exp_r = x & y;    exp_ov = 1'b0; end
            OP_OR:   begin exp_r = x | y;    exp_ov = 1'b0; end
            OP_NOR:  begin exp_r = ~(x | y); exp_ov = 1'b0; end
            OP_XOR:  begin exp_r = x ^ y;    exp_ov = 1'b0; end
            OP_ADD: begin
                p = sx + sy;
                exp_r  = p[31:0];
                exp_ov = (p > 64'sh7FFFFFFF) || (p < -64'sh80000000);
            end
            OP_SUB: begin
                p = sx - sy;
                exp_r  = p[31:0];
                exp_ov = (p > 64'sh7FFFFFFF) || (p < -64'sh80000000);
            end
            OP_SLT:  begin exp_r = (sx < sy) ? 32'd1 : 32'd0; exp_ov = 1'b0; end
            OP_SLTU: begin exp_r = (x < y)   ? 32'd1 : 32'd0; exp_ov = 1'b0; end
            OP_SRL:  begin exp_r = y >> x[4:0]; exp_ov = 1'b0; end
            OP_SRA:  begin p = sy >>> x[4:0]; exp_r = p[31:0]; exp_ov = 1'b0; end
            OP_SLL:  begin exp_r = y << x[4:0]; exp_ov = 1'b0; end
            OP_MULT: begin
                p = sx * sy;
                {exp_hi, exp_lo} = p;
                exp_ov = 1'b0; exp_lat = 33;
            end
            OP_MULTU: begin
                up = {32'd0, x} * {32'd0, y};
                {exp_hi, exp_lo} = up;
                exp_ov = 1'b0; exp_lat = 33;
            end
            OP_DIV: begin
                if (y == 32'd0) begin
                    exp_lo = 32'hFFFFFFFF; exp_hi = x;
                end else if (x == 32'h80000000 && y == 32'hFFFFFFFF) begin
                    exp_lo = 32'h80000000; exp_hi = 32'd0;
                end else begin
                    p = sx / sy; exp_lo = p[31:0];
                    p = sx % sy; exp_hi = p[31:0];
                end
                exp_ov = 1'b0; exp_lat = 33;
            end
            OP_DIVU: begin
                if (y == 32'd0) begin
                    exp_lo = 32'hFFFFFFFF; exp_hi = x;
                end else begin
                    exp_lo = x / y; exp_hi = x % y;
                end
                exp_ov = 1'b0; exp_lat = 33;
            end
            default: begin exp_r = 32'd0; exp_ov = 1'b0; end
        endcase
    endtask

    // Issue one operation on the 32-bit DUT (entered on a negedge) and check
    // latency, results, pulse width and handshake.
    task automatic do_op(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y,
                         input logic cin, input string tag);
        int lat;
        int guard;
        model(op, x, y);
        guard = 0;
        while (!in_ready && guard < 100) begin @(negedge clk); guard++; end
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL %s in_ready_wait: got %b want 1", tag, in_ready);
        end
        control = op; a = x; b = y; in_valid = 1'b1; cancel = cin;
        @(negedge clk);
        in_valid = 1'b0; cancel = 1'b0;
        a = $urandom; b = $urandom; control = 5'($urandom);
        lat = 1;
        while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
        n_tests++;
        if (lat !== exp_lat) begin
            n_fail++; $display("FAIL %s latency: got %0d want %0d", tag, lat, exp_lat);
        end
        n_tests++;
        if (r !== exp_r) begin
            n_fail++; $display("FAIL %s r: got %h want %h", tag, r, exp_r);
        end
        n_tests++;
        if (hi !== exp_hi || lo !== exp_lo) begin
            n_fail++; $display("FAIL %s hi/lo: got %h/%h want %h/%h", tag, hi, lo, exp_hi, exp_lo);
        end
        n_tests++;
        if (intov !== exp_ov) begin
            n_fail++; $display("FAIL %s intov: got %b want %b", tag, intov, exp_ov);
        end
        n_tests++;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL %s in_ready_done: got %b want 0", tag, in_ready);
        end
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL %s after_done: out_valid %b in_ready %b want 0 1", tag, out_valid, in_ready);
        end
    endtask

    // Issue one multiply/divide on the 8-bit DUT with its own inline model.
    task automatic do_op8(input logic [4:0] op, input logic [7:0] x, input logic [7:0] y);
        int         sx, sy, p, lat, guard;
        logic [7:0] eh, el;
        sx = int'($signed(x));
        sy = int'($signed(y));
        case (op)
            OP_MULT:  begin p = sx * sy; eh = p[15:8]; el = p[7:0]; end
            OP_MULTU: begin p = int'(x) * int'(y); eh = p[15:8]; el = p[7:0]; end
            OP_DIV: begin
                if (y == 8'd0) begin el = 8'hFF; eh = x; end
                else begin p = sx / sy; el = p[7:0]; p = sx % sy; eh = p[7:0]; end
            end
            default: begin
                if (y == 8'd0) begin el = 8'hFF; eh = x; end
                else begin el = x / y; eh = x % y; end
            end
        endcase
        guard = 0;
        while (!in_ready8 && guard < 100) begin @(negedge clk); guard++; end
        control8 = op; a8 = x; b8 = y; in_valid8 = 1'b1;
        @(negedge clk);
        in_valid8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
        lat = 1;
        while (!out_valid8 && lat < 100) begin @(negedge clk); lat++; end
        n_tests++;
        if (lat !== 9 || hi8 !== eh || lo8 !== el || intov8 !== 1'b0) begin
            n_fail++;
            $display("FAIL w8 op%b %h,%h: lat %0d hi %h lo %h ov %b want lat 9 hi %h lo %h ov 0",
                     op, x, y, lat, hi8, lo8, intov8, eh, el);
        end
        @(negedge clk);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h00000000;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'h7FFFFFFF;
            4: return 32'h00000001;
            default: return $urandom;
        endcase
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        in_valid = 1'b0; cancel = 1'b0; a = 32'd0; b = 32'd0; control = 5'd0;
        in_valid8 = 1'b0; cancel8 = 1'b0; a8 = 8'd0; b8 = 8'd0; control8 = 5'd0;
        exp_r = 32'd0; exp_hi = 32'd0; exp_lo = 32'd0; exp_ov = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0 || r !== 32'd0 || hi !== 32'd0 || lo !== 32'd0 || intov !== 1'b0) begin
            n_fail++; $display("FAIL reset_state: ov %b r %h hi %h lo %h intov %b want all 0",
                               out_valid, r, hi, lo, intov);
        end
        reset = 1'b1;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready: got %b want 1", in_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_directed();
        do_op(OP_ADD, 32'h7FFFFFFF, 32'h00000001, 1'b0, "add_ovf");
        n_tests++;
        if (r !== 32'h80000000 || intov !== 1'b1) begin
            n_fail++; $display("FAIL add_ovf_const: r %h intov %b want 80000000 1", r, intov);
        end
        do_op(OP_SUB, 32'd5, 32'd7, 1'b0, "sub");
        n_tests++;
        if (r !== 32'hFFFFFFFE || intov !== 1'b0) begin
            n_fail++; $display("FAIL sub_const: r %h intov %b want FFFFFFFE 0", r, intov);
        end
        do_op(OP_SRA, 32'd4, 32'h80000000, 1'b0, "sra");
        n_tests++;
        if (r !== 32'hF8000000) begin
            n_fail++; $display("FAIL sra_const: r %h want F8000000", r);
        end
        do_op(OP_SRL, 32'd32, 32'h12345678, 1'b0, "srl0");
        n_tests++;
        if (r !== 32'h12345678) begin
            n_fail++; $display("FAIL srl0_const: r %h want 12345678", r);
        end
        do_op(OP_MULT, 32'hFFFFFFFF, 32'd2, 1'b0, "mult");
        n_tests++;
        if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFE || r !== 32'h12345678) begin
            n_fail++; $display("FAIL mult_const: hi %h lo %h r %h want FFFFFFFF FFFFFFFE 12345678", hi, lo, r);
        end
        do_op(OP_MULTU, 32'hFFFFFFFF, 32'd2, 1'b0, "multu");
        n_tests++;
        if (hi !== 32'd1 || lo !== 32'hFFFFFFFE) begin
            n_fail++; $display("FAIL multu_const: hi %h lo %h want 00000001 FFFFFFFE", hi, lo);
        end
        do_op(OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, "div");
        n_tests++;
        if (lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF) begin
            n_fail++; $display("FAIL div_const: lo %h hi %h want FFFFFFFD FFFFFFFF", lo, hi);
        end
        do_op(OP_DIVU, 32'd9, 32'd0, 1'b0, "divu_by0");
        n_tests++;
        if (lo !== 32'hFFFFFFFF || hi !== 32'd9) begin
            n_fail++; $display("FAIL divu_by0_const: lo %h hi %h want FFFFFFFF 00000009", lo, hi);
        end
        do_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, "div_minneg");
        n_tests++;
        if (lo !== 32'h80000000 || hi !== 32'd0) begin
            n_fail++; $display("FAIL div_minneg_const: lo %h hi %h want 80000000 00000000", lo, hi);
        end
        do_op(OP_DIV, 32'hFFFFFFF0, 32'd0, 1'b0, "div_by0");
        do_op(5'b11111, 32'h1234, 32'h5678, 1'b0, "illegal");
        do_op(OP_SLT, 32'h80000000, 32'h7FFFFFFF, 1'b0, "slt_extreme");
        do_op(OP_SLTU, 32'h80000000, 32'h7FFFFFFF, 1'b0, "sltu_extreme");
        // cancel together with an accept in IDLE must not block the accept
        do_op(OP_MULTU, 32'd1000, 32'd3000, 1'b1, "cancel_idle");
    endtask

    task automatic test_random();
        logic [4:0] op;
        for (int i = 0; i < 150; i++) begin
            op = 5'($urandom_range(0, 31));
            do_op(op, pick(), pick(), 1'b0, "rand");
        end
    endtask

    task automatic test_cancel();
        int guard;
        int seen;
        guard = 0;
        while (!in_ready && guard < 100) begin @(negedge clk); guard++; end
        control = OP_DIVU; a = 32'd1000; b = 32'd7; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL cancel_ready: in_ready %b out_valid %b want 1 0", in_ready, out_valid);
        end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        n_tests++;
        if (seen !== 0) begin
            n_fail++; $display("FAIL cancel_no_valid: got %0d pulses want 0", seen);
        end
        n_tests++;
        if (r !== exp_r || hi !== exp_hi || lo !== exp_lo || intov !== exp_ov) begin
            n_fail++; $display("FAIL cancel_hold: r %h hi %h lo %h ov %b want %h %h %h %b",
                               r, hi, lo, intov, exp_r, exp_hi, exp_lo, exp_ov);
        end
        do_op(OP_AND, 32'hF0, 32'h3C, 1'b0, "and_after_cancel");
        n_tests++;
        if (r !== 32'h30) begin
            n_fail++; $display("FAIL and_after_cancel_const: r %h want 00000030", r);
        end
    endtask

    task automatic test_reset_mid();
        int guard;
        int seen;
        guard = 0;
        while (!in_ready && guard < 100) begin @(negedge clk); guard++; end
        control = OP_MULT; a = 32'h1234; b = 32'h5678; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b0;
        #1;
        exp_r = 32'd0; exp_hi = 32'd0; exp_lo = 32'd0; exp_ov = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0 || r !== 32'd0 || hi !== 32'd0 || lo !== 32'd0 || intov !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid: ov %b r %h hi %h lo %h intov %b want all 0",
                               out_valid, r, hi, lo, intov);
        end
        @(negedge clk);
        reset = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        n_tests++;
        if (seen !== 0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_mid_after: pulses %0d in_ready %b want 0 1", seen, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        int         start;
        logic [4:0] ops [0:7];
        ops[0] = OP_ADD; ops[1] = OP_XOR; ops[2] = OP_SLL; ops[3] = OP_SUB;
        ops[4] = OP_SLT; ops[5] = OP_NOR; ops[6] = OP_SRA; ops[7] = OP_OR;
        start = cyc;
        for (int i = 0; i < 8; i++) begin
            do_op(ops[i], pick(), pick(), 1'b0, "b2b");
        end
        n_tests++;
        if (cyc - start !== 16) begin
            n_fail++; $display("FAIL b2b_interval: got %0d cycles want 16", cyc - start);
        end
    endtask

    task automatic test_width8();
        do_op8(OP_MULTU, 8'hFF, 8'hFF);
        n_tests++;
        if (hi8 !== 8'hFE || lo8 !== 8'h01) begin
            n_fail++; $display("FAIL w8_multu_const: hi %h lo %h want FE 01", hi8, lo8);
        end
        do_op8(OP_DIV, 8'h80, 8'hFF);
        do_op8(OP_DIV, 8'hF9, 8'h02);
        for (int i = 0; i < 16; i++) begin
            do_op8(5'($urandom_range(0, 3)) == 5'd0 ? OP_MULT :
                   ($urandom_range(0, 2) == 0 ? OP_MULTU : ($urandom_range(0, 1) == 0 ? OP_DIV : OP_DIVU)),
                   8'($urandom), 8'($urandom_range(0, 12)));
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_cancel();
        test_reset_mid();
        test_back_to_back();
        test_width8();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
